// File: rtl/crc32_pkg.sv
// Shared constants, bit-order helpers and controller state encoding for the
// Ethernet CRC-32 frame path.
package crc32_pkg;

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [31:0] SEED    = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  // One byte through the MSB-first register; the wire-order byte is mirrored
  // so that wire bit 0 lands on the register MSB.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {bitrev8(b), 24'h000000};
    for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_next.sv
// Combinational CRC-32 next state for 1..4 bytes of a word, byte 0 first.
module crc32_next
  import crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] crc_out
);

  // Chain up to four byte updates, stopping after nbytes.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no path leaves it unassigned and no latch is inferred.
    crc_out = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes) crc_out = crc32_byte(crc_out, data[8*i +: 8]);
    end
  end

endmodule

// File: rtl/crc32_frame_ctl.sv
// Frame sequencer: runs accepted words through the CRC, presents the FCS at
// end of frame and flags good/bad residue and framing violations.
module crc32_frame_ctl
  import crc32_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter logic [31:0] RESIDUE = crc32_pkg::RESIDUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic             s_eof,
  input  logic [1:0]       s_bcnt,
  output logic [31:0]      fcs_data,
  output logic             fcs_valid,
  input  logic             fcs_ready,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [LEN_W-1:0] frame_len,
  output logic             proto_err
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_e           state_q, state_d;
  logic [31:0]      crc_q, crc_d, crc_base, crc_upd;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_base, cnt_upd;
  logic [LEN_W:0]   cnt_sum;
  logic [2:0]       nbytes;
  logic             accept, frame_end, proto_d;

  assign accept    = s_valid & s_ready;
  assign fcs_valid = (state_q == DONE);

  // Byte count of this word; a zero count on the eof word means all four.
  assign nbytes = (s_eof && s_bcnt != 2'd0) ? {1'b0, s_bcnt} : 3'd4;

  // A sof word always starts from the seed, whether from IDLE or as a restart.
  assign crc_base = s_sof ? SEED : crc_q;
  assign cnt_base = s_sof ? '0 : cnt_q;
  assign cnt_sum  = {1'b0, cnt_base} + (LEN_W+1)'(nbytes);
  assign cnt_upd  = cnt_sum[LEN_W] ? LEN_MAX : cnt_sum[LEN_W-1:0];

  crc32_next u_next (
    .crc_in (crc_base),
    .data   (s_data),
    .nbytes (nbytes),
    .crc_out(crc_upd)
  );

  // Next-state and datapath-enable decode for the frame FSM.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    proto_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_sof) begin
            crc_d     = crc_upd;
            cnt_d     = cnt_upd;
            frame_end = s_eof;
            state_d   = s_eof ? DONE : RUN;
          end else begin
            proto_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          crc_d     = crc_upd;
          cnt_d     = cnt_upd;
          frame_end = s_eof;
          proto_d   = s_sof;
          if (s_eof) state_d = DONE;
        end
      end
      DONE: begin
        if (fcs_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, CRC/count registers and registered frame-end outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      state_q   <= IDLE;
      crc_q     <= SEED;
      cnt_q     <= '0;
      s_ready   <= 1'b0;
      fcs_data  <= '0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      proto_err <= 1'b0;
      frame_len <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      s_ready   <= (state_d != DONE);
      crc_ok    <= frame_end && (crc_d == RESIDUE);
      crc_err   <= frame_end && (crc_d != RESIDUE);
      proto_err <= proto_d;
      if (frame_end) begin
        frame_len <= cnt_d;
        fcs_data  <= ~bitrev32(crc_d);
      end
    end
  end

endmodule

// File: tb/tb_crc32_frame_ctl.sv
// Self-checking bench for crc32_frame_ctl: vector table plus hand-written
// sequences for FCS back-pressure and reset mid-frame / in DONE.
module tb_crc32_frame_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid, s_ready, s_sof, s_eof;
  logic [1:0]  s_bcnt;
  logic [31:0] fcs_data;
  logic        fcs_valid, fcs_ready;
  logic        crc_ok, crc_err, proto_err;
  logic [15:0] frame_len;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  crc32_frame_ctl #(.LEN_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sof    (s_sof),
    .s_eof    (s_eof),
    .s_bcnt   (s_bcnt),
    .fcs_data (fcs_data),
    .fcs_valid(fcs_valid),
    .fcs_ready(fcs_ready),
    .crc_ok   (crc_ok),
    .crc_err  (crc_err),
    .frame_len(frame_len),
    .proto_err(proto_err)
  );

  typedef struct {
    logic        v, sof, eof;
    logic [1:0]  bcnt;
    logic [31:0] data;
    logic        fr;
    logic        e_rdy, e_fv, e_ok, e_err, e_perr;
    logic [15:0] e_len;
    logic        chk_fcs;
    logic [31:0] e_fcs;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sof, input logic eof, input logic [1:0] bcnt,
                       input logic [31:0] data, input logic fr);
    s_valid   = v;
    s_sof     = sof;
    s_eof     = eof;
    s_bcnt    = bcnt;
    s_data    = data;
    fcs_ready = fr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic rdy, input logic fv, input logic ok,
                           input logic err, input logic perr, input logic [15:0] len);
    check({tag, " s_ready"},   32'(s_ready),   32'(rdy));
    check({tag, " fcs_valid"}, 32'(fcs_valid), 32'(fv));
    check({tag, " crc_ok"},    32'(crc_ok),    32'(ok));
    check({tag, " crc_err"},   32'(crc_err),   32'(err));
    check({tag, " proto_err"}, 32'(proto_err), 32'(perr));
    check({tag, " frame_len"}, 32'(frame_len), 32'(len));
  endtask

  // "123456789" in three words; returns just after the eof edge with s_valid low.
  task automatic send_std(input logic fr);
    drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h34333231, fr); tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h38373635, fr); tick();
    drive(1'b1, 1'b0, 1'b1, 2'd1, 32'h00000039, fr); tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, fr);
  endtask

  initial begin
    //                 v  sof eof bcnt data          fr  rdy fv ok err perr len    chk fcs
    // "123456789" -> check value, frame_len 9
    tbl.push_back('{1, 1, 0, 0, 32'h34333231, 0, 1, 0, 0, 0, 0, 16'd0,  0, 32'h0});
    tbl.push_back('{1, 0, 0, 0, 32'h38373635, 0, 1, 0, 0, 0, 0, 16'd0,  0, 32'h0});
    tbl.push_back('{1, 0, 1, 1, 32'h00000039, 0, 0, 1, 0, 1, 0, 16'd9,  1, 32'hCBF43926});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 16'd9,  0, 32'h0});
    // Same frame plus its FCS, fcs_ready held high -> good residue, FCS of residue
    tbl.push_back('{1, 1, 0, 0, 32'h34333231, 1, 1, 0, 0, 0, 0, 16'd9,  0, 32'h0});
    tbl.push_back('{1, 0, 0, 0, 32'h38373635, 1, 1, 0, 0, 0, 0, 16'd9,  0, 32'h0});
    tbl.push_back('{1, 0, 0, 0, 32'hF4392639, 1, 1, 0, 0, 0, 0, 16'd9,  0, 32'h0});
    tbl.push_back('{1, 0, 1, 1, 32'h000000CB, 1, 0, 1, 1, 0, 0, 16'd13, 1, 32'h2144DF1C});
    // Word offered while in DONE is not taken; fcs_valid lasts one cycle
    tbl.push_back('{1, 1, 1, 0, 32'hDEADBEEF, 1, 1, 0, 0, 0, 0, 16'd13, 0, 32'h0});
    // One payload bit flipped -> bad residue
    tbl.push_back('{1, 1, 0, 0, 32'h34333230, 1, 1, 0, 0, 0, 0, 16'd13, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0, 32'h38373635, 1, 1, 0, 0, 0, 0, 16'd13, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0, 32'hF4392639, 1, 1, 0, 0, 0, 0, 16'd13, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 1, 32'h000000CB, 1, 0, 1, 0, 1, 0, 16'd13, 0, 32'h0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 16'd13, 0, 32'h0});
    // Words without sof in IDLE are dropped with proto_err
    tbl.push_back('{1, 0, 0, 0, 32'h12345678, 1, 1, 0, 0, 0, 1, 16'd13, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 2, 32'h12345678, 1, 1, 0, 0, 0, 1, 16'd13, 0, 32'h0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 16'd13, 0, 32'h0});
    // sof mid-frame restarts; aborted frame gives no FCS
    tbl.push_back('{1, 1, 0, 0, 32'h11111111, 1, 1, 0, 0, 0, 0, 16'd13, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 0, 32'h34333231, 1, 1, 0, 0, 0, 1, 16'd13, 0, 32'h0});
    tbl.push_back('{1, 0, 0, 0, 32'h38373635, 1, 1, 0, 0, 0, 0, 16'd13, 0, 32'h0});
    tbl.push_back('{1, 0, 1, 1, 32'h00000039, 1, 0, 1, 0, 1, 0, 16'd9,  1, 32'hCBF43926});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 16'd9,  0, 32'h0});
    // Single-word frames: bcnt 0 means 4 bytes, bcnt 3 means 3
    tbl.push_back('{1, 1, 1, 0, 32'h34333231, 1, 0, 1, 0, 1, 0, 16'd4,  0, 32'h0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 16'd4,  0, 32'h0});
    tbl.push_back('{1, 1, 1, 3, 32'h00333231, 1, 0, 1, 0, 1, 0, 16'd3,  0, 32'h0});
    tbl.push_back('{0, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 16'd3,  0, 32'h0});

    // Reset state
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    tick(); tick();
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset fcs_data", fcs_data, 32'h0);
    rst = 1'b1;
    tick();
    check("post-reset s_ready", 32'(s_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].sof, tbl[i].eof, tbl[i].bcnt, tbl[i].data, tbl[i].fr);
      tick();
      check_ctl($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_fv, tbl[i].e_ok,
                tbl[i].e_err, tbl[i].e_perr, tbl[i].e_len);
      if (tbl[i].chk_fcs) check($sformatf("vec%0d fcs_data", i), fcs_data, tbl[i].e_fcs);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);

    // FCS back-pressure: hold fcs_ready low 5 cycles while words are offered
    send_std(1'b0);
    check_ctl("hold eof+1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9);
    check("hold eof+1 fcs_data", fcs_data, 32'hCBF43926);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 2'd0, 32'h34333231, 1'b0);
      tick();
      check_ctl($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd9);
      check($sformatf("hold%0d fcs_data", i), fcs_data, 32'hCBF43926);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
    tick();
    check_ctl("release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9);

    // Reset for one cycle in RUN
    drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h34333231, 1'b0); tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h38373635, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    check_ctl("rst run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("rst run fcs_data", fcs_data, 32'h0);
    rst = 1'b1;
    tick();
    check("rst run ready", 32'(s_ready), 32'd1);
    send_std(1'b0);
    check_ctl("after rst run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9);
    check("after rst run fcs_data", fcs_data, 32'hCBF43926);

    // Reset for one cycle in DONE
    rst = 1'b0;
    tick();
    check_ctl("rst done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("rst done fcs_data", fcs_data, 32'h0);
    rst = 1'b1;
    tick();
    check_ctl("rst done exit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    send_std(1'b1);
    check_ctl("after rst done", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd9);
    check("after rst done fcs_data", fcs_data, 32'hCBF43926);
    tick();
    check_ctl("final idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
